// File: rtl/op_feeder_pkg.sv
// Shared types and constants for the op feeder: FSM states, the load opcode,
// the feature-map size and the byte FIFO depth.
package op_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_RDY = 2'd1,
    ST_ISSUE    = 2'd2,
    ST_LOAD     = 2'd3
  } feed_state_t;

  localparam logic [3:0] OP_LOAD    = 4'd0;
  localparam int         MAP_BYTES  = 2048;
  localparam int         FIFO_DEPTH = 16;
  localparam int         LOAD_CNT_W = $clog2(MAP_BYTES);

endpackage

// File: rtl/op_feeder_fifo.sv
// feed_fifo: synchronous FIFO with registered storage and full/empty flags.
// A push is refused when full, even if a pop happens in the same cycle.
module feed_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int            AW   = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: the pointers/count decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/op_feeder.sv
// op_feeder: accepts host op commands, issues them to the core and streams a
// 2048-byte feature map on load ops. Statistics counters exist only when
// FEED_STATS_EN is defined; otherwise o_op_count/o_stall_cnt read 0.
//
// state       | meaning
// ------------+----------------------------------------------------------
// ST_IDLE     | ready for a host command
// ST_WAIT_RDY | command latched, waiting for the core to be ready
// ST_ISSUE    | one-cycle op strobe to the core
// ST_LOAD     | streaming feature-map bytes from the FIFO to the core
module op_feeder
  import op_feeder_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cmd_valid,
  input  logic [3:0]  i_cmd_mode,
  output logic        o_cmd_ready,
  input  logic        i_hd_valid,
  input  logic [7:0]  i_hd_data,
  output logic        o_hd_ready,
  input  logic        i_op_ready,
  output logic        o_op_valid,
  output logic [3:0]  o_op_mode,
  output logic        o_in_valid,
  output logic [7:0]  o_in_data,
  input  logic        i_in_ready,
  output logic        o_busy,
  output logic [9:0]  o_op_count,
  output logic [15:0] o_stall_cnt
);

  feed_state_t           state;
  feed_state_t           state_nx;
  logic [3:0]            mode_q;
  logic [3:0]            op_mode_q;
  logic                  op_valid_q;
  logic [LOAD_CNT_W-1:0] load_cnt;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [7:0]            fifo_head;
  logic                  cmd_fire;
  logic                  in_fire;
  logic                  load_last;

  assign o_cmd_ready = (state == ST_IDLE);
  assign o_busy      = (state != ST_IDLE);
  assign o_hd_ready  = !fifo_full;
  assign o_in_valid  = (state == ST_LOAD) && !fifo_empty;
  assign o_in_data   = (state == ST_LOAD) ? fifo_head : 8'd0;
  assign o_op_valid  = op_valid_q;
  assign o_op_mode   = op_mode_q;

  assign cmd_fire  = i_cmd_valid && o_cmd_ready;
  assign in_fire   = o_in_valid && i_in_ready;
  assign load_last = in_fire && (load_cnt == LOAD_CNT_W'(MAP_BYTES - 1));

  feed_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (i_hd_valid),
    .wdata (i_hd_data),
    .pop   (in_fire),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:     if (cmd_fire) state_nx = ST_WAIT_RDY;
      ST_WAIT_RDY: if (i_op_ready) state_nx = ST_ISSUE;
      ST_ISSUE:    state_nx = (mode_q == OP_LOAD) ? ST_LOAD : ST_IDLE;
      ST_LOAD:     if (load_last) state_nx = ST_IDLE;
      default:     state_nx = ST_IDLE;
    endcase
  end

  // The op strobe and mode are registered off the next state so both line up
  // with the single ISSUE cycle; the mode then holds until the next issue.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      mode_q     <= '0;
      op_valid_q <= 1'b0;
      op_mode_q  <= '0;
      load_cnt   <= '0;
    end else begin
      state      <= state_nx;
      op_valid_q <= (state_nx == ST_ISSUE);
      if (cmd_fire) mode_q <= i_cmd_mode;
      if (state_nx == ST_ISSUE) op_mode_q <= mode_q;
      if (in_fire) load_cnt <= load_last ? '0 : load_cnt + 1'b1;
    end
  end

`ifdef FEED_STATS_EN
  logic [9:0]  op_count;
  logic [15:0] stall_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_count  <= '0;
      stall_cnt <= '0;
    end else begin
      if (state == ST_ISSUE) op_count <= op_count + 10'd1;
      if (o_in_valid && !i_in_ready && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign o_op_count  = op_count;
  assign o_stall_cnt = stall_cnt;
`else
  assign o_op_count  = '0;
  assign o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_op_feeder.sv
// Self-checking bench for op_feeder: a queue-based reference model of the
// command/load protocol is compared against the DUT every cycle.
`timescale 1ns/1ps
module tb_op_feeder;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_cmd_valid = 1'b0;
  logic [3:0]  i_cmd_mode = 4'd0;
  logic        i_hd_valid = 1'b0;
  logic [7:0]  i_hd_data = 8'd0;
  logic        i_op_ready = 1'b0;
  logic        i_in_ready = 1'b0;
  logic        o_cmd_ready;
  logic        o_hd_ready;
  logic        o_op_valid;
  logic [3:0]  o_op_mode;
  logic        o_in_valid;
  logic [7:0]  o_in_data;
  logic        o_busy;
  logic [9:0]  o_op_count;
  logic [15:0] o_stall_cnt;

  always #5 i_clk = ~i_clk;

  op_feeder dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_cmd_valid (i_cmd_valid),
    .i_cmd_mode  (i_cmd_mode),
    .o_cmd_ready (o_cmd_ready),
    .i_hd_valid  (i_hd_valid),
    .i_hd_data   (i_hd_data),
    .o_hd_ready  (o_hd_ready),
    .i_op_ready  (i_op_ready),
    .o_op_valid  (o_op_valid),
    .o_op_mode   (o_op_mode),
    .o_in_valid  (o_in_valid),
    .o_in_data   (o_in_data),
    .i_in_ready  (i_in_ready),
    .o_busy      (o_busy),
    .o_op_count  (o_op_count),
    .o_stall_cnt (o_stall_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: phases follow the protocol rules, the FIFO is a queue.
  localparam int P_IDLE = 0, P_WAIT = 1, P_ISSUE = 2, P_LOAD = 3;
  logic [7:0] m_q[$];
  logic [7:0] m_out[$];
  logic [7:0] dut_out[$];
  int         m_phase = P_IDLE;
  logic [3:0] m_mode = 4'd0;
  logic [3:0] m_issued = 4'd0;
  int         m_loaded = 0;
  int         m_opcnt = 0;
  int         m_stall = 0;
  int         m_pushes = 0;
  bit         m_full;

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_q.delete();
      m_phase  = P_IDLE;
      m_mode   = 4'd0;
      m_issued = 4'd0;
      m_loaded = 0;
      m_opcnt  = 0;
      m_stall  = 0;
    end else begin
      m_full = (m_q.size() == 16);
      case (m_phase)
        P_IDLE: if (i_cmd_valid) begin m_mode = i_cmd_mode; m_phase = P_WAIT; end
        P_WAIT: if (i_op_ready) begin m_phase = P_ISSUE; m_issued = m_mode; end
        P_ISSUE: begin
          m_opcnt = (m_opcnt + 1) % 1024;
          m_phase = (m_mode == 4'd0) ? P_LOAD : P_IDLE;
        end
        default: if (m_q.size() > 0) begin
          if (i_in_ready) begin
            m_out.push_back(m_q.pop_front());
            m_loaded++;
            if (m_loaded == 2048) begin m_loaded = 0; m_phase = P_IDLE; end
          end else if (m_stall < 65535) m_stall++;
        end
      endcase
      if (i_hd_valid && !m_full) begin
        m_q.push_back(i_hd_data);
        m_pushes++;
      end
    end
  end

  // Record what the core actually receives (pre-edge values).
  always @(posedge i_clk) begin
    if (i_rst_n && o_in_valid && i_in_ready) dut_out.push_back(o_in_data);
  end

  task automatic check_outputs();
    chk("busy", o_busy, m_phase != P_IDLE);
    chk("cmd_ready", o_cmd_ready, m_phase == P_IDLE);
    chk("hd_ready", o_hd_ready, m_q.size() < 16);
    chk("op_valid", o_op_valid, m_phase == P_ISSUE);
    chk("op_mode", o_op_mode, m_issued);
    chk("in_valid", o_in_valid, (m_phase == P_LOAD) && (m_q.size() > 0));
    if (m_phase == P_LOAD && m_q.size() > 0) chk("in_data", o_in_data, m_q[0]);
`ifdef FEED_STATS_EN
    chk("op_count", o_op_count, m_opcnt);
    chk("stall_cnt", o_stall_cnt, m_stall);
`else
    chk("op_count_tied", o_op_count, 0);
    chk("stall_cnt_tied", o_stall_cnt, 0);
`endif
  endtask

  // Stimulus modes: host 0=quiet 1=random bytes 2=counting bytes;
  // core ready 0=low 1=high 2=random 3=toggle.
  int host_mode = 0;
  int rdy_mode  = 0;
  int push_base = 0;

  task automatic tick();
    @(negedge i_clk);
    check_outputs();
    case (host_mode)
      1: begin i_hd_valid = ($urandom_range(0, 99) < 80); i_hd_data = 8'($urandom); end
      2: begin i_hd_valid = 1'b1; i_hd_data = 8'(m_pushes - push_base); end
      default: i_hd_valid = 1'b0;
    endcase
    case (rdy_mode)
      1: i_in_ready = 1'b1;
      2: i_in_ready = 1'($urandom_range(0, 1));
      3: i_in_ready = ~i_in_ready;
      default: i_in_ready = 1'b0;
    endcase
  endtask

  task automatic send_cmd(input logic [3:0] mode);
    i_cmd_valid = 1'b1;
    i_cmd_mode  = mode;
    tick();
    i_cmd_valid = 1'b0;
    i_cmd_mode  = 4'($urandom);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((o_busy || m_phase != P_IDLE) && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, o_busy, 0);
  endtask

  task automatic reset_dut();
    i_rst_n = 1'b0;
    tick();
    tick();
    i_rst_n = 1'b1;
    tick();
    m_out.delete();
    dut_out.delete();
  endtask

  task automatic order_check(input string tag, input int exp_n);
    int bad = 0;
    chk({tag, "_count"}, dut_out.size(), exp_n);
    for (int k = 0; k < dut_out.size() && k < m_out.size(); k++)
      if (dut_out[k] !== m_out[k]) bad++;
    chk({tag, "_order"}, bad, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int pulses;
    logic [3:0] seen_mode;
    int bad;
    int n;

    repeat (3) @(negedge i_clk);
    chk("rst_cmd_ready", o_cmd_ready, 1);
    chk("rst_hd_ready", o_hd_ready, 1);
    chk("rst_in_valid", o_in_valid, 0);
    chk("rst_in_data", o_in_data, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_op_valid", o_op_valid, 0);
    chk("rst_op_mode", o_op_mode, 0);
    chk("rst_op_count", o_op_count, 0);
    chk("rst_stall_cnt", o_stall_cnt, 0);
    i_rst_n = 1'b1;
    tick();

    // Non-load op with the core always ready.
    i_op_ready = 1'b1;
    send_cmd(4'd7);
    chk("m7_no_early_strobe", o_op_valid, 0);
    pulses = 0;
    seen_mode = 4'd0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (o_op_valid) begin pulses++; seen_mode = o_op_mode; end
    end
    chk("m7_pulses", pulses, 1);
    chk("m7_mode", seen_mode, 7);
    chk("m7_idle", o_busy, 0);
`ifdef FEED_STATS_EN
    chk("m7_op_count", o_op_count, 1);
`endif

    // Fill the FIFO while idle, then load; first 16 bytes must be 0..15.
    push_base = m_pushes;
    host_mode = 2;
    repeat (20) tick();
    chk("fill_hd_ready_low", o_hd_ready, 0);
    host_mode = 0;
    rdy_mode  = 1;
    m_out.delete();
    dut_out.delete();
    send_cmd(4'd0);
    repeat (24) tick();
    bad = 0;
    for (int k = 0; k < 16; k++) if (dut_out[k] !== 8'(k)) bad++;
    chk("fill_first16", bad, 0);
    host_mode = 1;
    rdy_mode  = 2;
    wait_idle("fill_load", 12000);
    order_check("fill_load", 2048);

    // Full load with the host counting 0..255 and the core always ready.
    reset_dut();
    push_base = m_pushes;
    host_mode = 2;
    rdy_mode  = 1;
    send_cmd(4'd0);
    wait_idle("count_load", 6000);
    chk("count_load_n", dut_out.size(), 2048);
    bad = 0;
    for (int k = 0; k < dut_out.size(); k++) if (dut_out[k] !== 8'(k)) bad++;
    chk("count_load_pattern", bad, 0);

    // Load with the core ready toggling; a command is held during the load.
    reset_dut();
    host_mode = 1;
    rdy_mode  = 3;
    send_cmd(4'd0);
    i_cmd_valid = 1'b1;
    i_cmd_mode  = 4'd9;
    wait_idle("toggle_load", 12000);
    i_cmd_valid = 1'b0;
    order_check("toggle_load", 2048);
`ifdef FEED_STATS_EN
    chk("toggle_stalls", o_stall_cnt, m_stall);
    chk("toggle_stalls_seen", (m_stall > 0), 1);
`endif

    // Core not ready for 50 cycles after the handshake.
    host_mode = 0;
    i_op_ready = 1'b0;
    send_cmd(4'd5);
    pulses = 0;
    repeat (50) begin tick(); if (o_op_valid) pulses++; end
    chk("hold_no_strobe", pulses, 0);
    chk("hold_busy", o_busy, 1);
    i_op_ready = 1'b1;
    repeat (4) begin tick(); if (o_op_valid) pulses++; end
    chk("hold_one_strobe", pulses, 1);
    chk("hold_mode", o_op_mode, 5);

    // Reset in the middle of a load abandons it.
    reset_dut();
    host_mode = 1;
    rdy_mode  = 1;
    send_cmd(4'd0);
    n = 0;
    while (dut_out.size() < 1000 && n < 4000) begin tick(); n++; end
    chk("abort_reached", dut_out.size(), 1000);
    i_rst_n = 1'b0;
    #1;
    chk("abort_in_valid", o_in_valid, 0);
    chk("abort_hd_ready", o_hd_ready, 1);
    chk("abort_busy", o_busy, 0);
    tick();
    i_rst_n = 1'b1;
    tick();
    m_out.delete();
    dut_out.delete();
    send_cmd(4'd0);
    wait_idle("after_abort", 6000);
    order_check("after_abort", 2048);

    // Random non-load ops with a random core ready.
    host_mode = 1;
    rdy_mode  = 2;
    for (int j = 0; j < 8; j++) begin
      i_op_ready = 1'($urandom_range(0, 1));
      send_cmd(4'($urandom_range(1, 15)));
      n = 0;
      while (m_phase != P_IDLE && n < 200) begin
        tick();
        i_op_ready = 1'($urandom_range(0, 1));
        n++;
      end
      tick();
      chk("rand_idle", o_busy, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
